// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, fetches one instruction at a
// time over a req/ready handshake and computes the next PC from control_unit's
// pc_control decision when the current instruction leaves execute.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        stall,
  input  logic [3:0]  pc_control,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2
  } state_e;

  localparam logic [3:0] PcJump   = 4'b0001;
  localparam logic [3:0] PcJr     = 4'b0010;
  localparam logic [3:0] PcBranch = 4'b0011;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] next_pc;

  // Outputs are decoded straight from state so an asynchronous reset drops them at once.
  always_comb begin
    imem_req     = (state_q == StFetch);
    imem_addr    = pc_q;
    pc           = pc_q;
    pc_plus4     = pc_q + 32'd4;
    instruction  = instr_q;
    instr_valid  = valid_q;
    misalign_err = misalign_q;
  end

  // Next-PC selection from the decoded pc_control of the executing instruction.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_control)
      PcJump:   next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      PcJr:     next_pc = {jr_target[31:2], 2'b00};
      PcBranch: next_pc = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      default:  next_pc = pc_plus4;
    endcase
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    unique case (state_q)
      StBoot: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        // pc_control and jr_target only matter on the edge that leaves execute.
        if (!stall) begin
          pc_d    = next_pc;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          state_d = StFetch;
          if ((pc_control == PcJr) && (jr_target[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StBoot;
      pc_q       <= {RESET_VECTOR[31:2], 2'b00};
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= {pc_d[31:2], 2'b00};
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a driver acts as instruction memory
// and control_unit, pushing the expected (pc, instruction, misalign) of each fetch;
// a monitor pops and compares whenever the DUT presents a valid instruction.
module tb_instruction_fetch_unit;

  localparam logic [31:0] ResetVector = 32'h0000_0000;
  localparam logic [31:0] NopInstr    = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        stall;
  logic [3:0]  pc_control;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int checks = 0;
  int passed = 0;

  // Reference model state and scoreboard.
  logic [31:0] exp_pc;
  logic        exp_mis;
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  logic        q_mis[$];
  bit          mon_en = 0;

  instruction_fetch_unit #(
    .RESET_VECTOR(ResetVector),
    .NOP_INSTR   (NopInstr)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .stall       (stall),
    .pc_control  (pc_control),
    .jr_target   (jr_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Next PC from the instruction-set rules, in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic [3:0] sel, input logic [31:0] jr);
    logic [15:0] imm;
    int          off;
    imm = word[15:0];
    off = int'($signed(imm)) * 4;
    case (sel)
      4'd1:    return ((cur + 32'd4) & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
      4'd2:    return jr & ~32'd3;
      4'd3:    return cur + 32'd4 + 32'(off);
      default: return cur + 32'd4;
    endcase
  endfunction

  // One instruction: memory wait, execute stall, then exit with the given pc_control.
  task automatic do_instr(input logic [31:0] word, input int wait_cycles, input int stall_cycles,
                          input logic [3:0] sel, input logic [31:0] jr);
    int iters = 0;
    bit seen = 0;
    while (!seen && iters < 10) begin
      @(negedge clk);
      iters++;
      if (imem_req) seen = 1;
    end
    if (!seen) begin
      chk("req_timeout", 32'(imem_req), 32'd1);
      return;
    end
    chk("fetch_latency", 32'(iters), 32'd1);
    q_pc.push_back(exp_pc);
    q_ins.push_back(word);
    q_mis.push_back(exp_mis);
    stall = 1'($urandom_range(0, 1));
    imem_ready = 1'b0;
    imem_rdata = ~word;
    repeat (wait_cycles) @(negedge clk);
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    // Now executing: memory handshake must be ignored.
    imem_ready = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    repeat (stall_cycles) begin
      stall      = 1'b1;
      pc_control = 4'($urandom);
      jr_target  = $urandom;
      @(negedge clk);
    end
    stall      = 1'b0;
    pc_control = sel;
    jr_target  = jr;
    exp_pc     = model_next(exp_pc, word, sel, jr);
    if (sel == 4'd2 && jr[1:0] != 2'b00) exp_mis = 1'b1;
  endtask

  task automatic model_reset();
    exp_pc  = ResetVector;
    exp_mis = 1'b0;
    q_pc.delete();
    q_ins.delete();
    q_mis.delete();
  endtask

  // Monitor: compares presented instructions against the scoreboard.
  logic [31:0] cur_pc, cur_ins;
  logic        cur_mis;
  logic        prev_valid = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (instr_valid && !prev_valid) begin
        if (q_pc.size() == 0) begin
          chk("unexpected_instr", 32'(q_pc.size()), 32'd1);
        end else begin
          cur_pc  = q_pc.pop_front();
          cur_ins = q_ins.pop_front();
          cur_mis = q_mis.pop_front();
          chk("misalign_err", 32'(misalign_err), 32'(cur_mis));
        end
      end
      if (instr_valid) begin
        chk("exec_pc", pc, cur_pc);
        chk("exec_instr", instruction, cur_ins);
        chk("exec_pc_plus4", pc_plus4, cur_pc + 32'd4);
        chk("exec_no_req", 32'(imem_req), 32'd0);
      end else begin
        chk("idle_nop", instruction, NopInstr);
      end
      if (imem_req && q_pc.size() != 0) begin
        chk("fetch_addr", imem_addr, q_pc[0]);
        chk("fetch_pc_aligned", 32'(imem_addr[1:0]), 32'd0);
      end
    end
    prev_valid = instr_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    pc_control = 4'h0;
    jr_target  = 32'h0;
    model_reset();
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", pc, ResetVector);
    chk("rst_instr", instruction, NopInstr);
    chk("rst_mis", 32'(misalign_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1;

    // Sequential run with zero wait: pc 0, 4, 8, C.
    repeat (4) do_instr(32'h0000_0020, 0, 0, 4'd0, 32'h0);
    // Memory wait of 3 cycles at pc 0x10.
    do_instr(32'h0000_0020, 3, 0, 4'd0, 32'h0);
    // Jump from 0x1000_0040.
    do_instr(32'h0000_0020, 0, 0, 4'd2, 32'h1000_0040);
    do_instr(32'h0800_0100, 0, 0, 4'd1, 32'h0);
    // Branch taken and not taken from 0x100.
    do_instr(32'h0000_0020, 0, 0, 4'd2, 32'h0000_0100);
    do_instr(32'h1000_FFFE, 0, 0, 4'd3, 32'h0);
    do_instr(32'h0000_0020, 0, 0, 4'd2, 32'h0000_0100);
    do_instr(32'h1000_FFFE, 1, 0, 4'd0, 32'h0);
    // Misaligned jump register: sticky flag.
    do_instr(32'h0000_0020, 0, 0, 4'd2, 32'h0000_2003);
    do_instr(32'h0000_0020, 0, 5, 4'd0, 32'h0);
    do_instr(32'h0000_0020, 0, 0, 4'd0, 32'h0);
    // Wrap from the top of the address space.
    do_instr(32'h0000_0020, 0, 0, 4'd2, 32'hFFFF_FFFC);
    do_instr(32'h0000_0020, 0, 0, 4'd0, 32'h0);
    do_instr(32'h0000_0020, 0, 0, 4'd0, 32'h0);

    // Randomized instructions.
    for (int i = 0; i < 40; i++) begin
      do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               4'($urandom_range(0, 4)), $urandom);
    end

    // Reset while executing: instr_valid drops without a clock edge.
    begin : rst_exec
      bit seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (imem_req) seen = 1;
      end
      chk("pre_exec_req", 32'(imem_req), 32'd1);
      q_pc.push_back(exp_pc);
      q_ins.push_back(32'hA5A5_0001);
      q_mis.push_back(exp_mis);
      imem_ready = 1'b1;
      imem_rdata = 32'hA5A5_0001;
      @(negedge clk);
      stall = 1'b1;
      #3;
      mon_en = 0;
      rst = 1'b0;
      #1;
      chk("rst_exec_valid", 32'(instr_valid), 32'd0);
      chk("rst_exec_instr", instruction, NopInstr);
      @(negedge clk);
      stall = 1'b0;
      imem_ready = 1'b0;
      rst = 1'b1;
      model_reset();
      mon_en = 1;
    end
    do_instr(32'h0000_0020, 0, 0, 4'd0, 32'h0);
    do_instr(32'h0000_0020, 2, 1, 4'd0, 32'h0);

    // Reset while fetching: imem_req drops at once, flow restarts from boot.
    begin : rst_fetch
      bit seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (imem_req) seen = 1;
      end
      mon_en = 0;
      imem_ready = 1'b0;
      #1;
      chk("pre_fetch_req", 32'(imem_req), 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_fetch_req", 32'(imem_req), 32'd0);
      chk("rst_fetch_pc", pc, ResetVector);
      chk("rst_fetch_mis", 32'(misalign_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      mon_en = 1;
    end
    do_instr(32'h0000_0020, 0, 0, 4'd0, 32'h0);
    do_instr(32'h0000_0020, 0, 0, 4'd0, 32'h0);

    repeat (3) @(negedge clk);
    chk("queue_drain", 32'(q_pc.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Program-counter owner and instruction source for the CPU.
- Fetches one instruction at a time from instruction memory using a req/ready handshake.
- Presents the fetched instruction to control_unit.
- Consumes control_unit's pc_control and alu_zero-qualified branch decision to compute the next PC.
- Forms the producer/consumer pair with control_unit: control_unit decodes the instruction, and this block acts on the resulting pc_control.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, value driven on instruction while instr_valid=0.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  word-aligned fetch address (= pc).
imem_ready  input  1  memory accepts the request and returns imem_rdata in the same cycle.
imem_rdata  input  32  fetched instruction word.
instruction  output  32  instruction presented to control_unit.
instr_valid  output  1  instruction is valid and being executed.
stall  input  1  hold the current instruction in the execute state.
pc_control  input  4  next-PC select from control_unit.
jr_target  input  32  rs register value, used for jump-register.
pc  output  32  address of the current instruction.
pc_plus4  output  32  pc + 4, combinational.
misalign_err  output  1  sticky flag: a jump-register target was misaligned.

Behaviour:
- Reset (rst=0, asynchronous) drives:
  - pc = RESET_VECTOR
  - imem_req = 0
  - instr_valid = 0
  - instruction = NOP_INSTR
  - misalign_err = 0
  - state = BOOT
- States: BOOT, FETCH, EXEC.
- BOOT: first clock edge after rst releases goes to FETCH. imem_req = 0 in BOOT.
- FETCH:
  - imem_req = 1 and imem_addr = pc, held stable until a clock edge where imem_ready = 1.
  - At that edge, instruction is loaded from imem_rdata, instr_valid goes to 1, and state goes to EXEC.
  - imem_ready sampled in the first FETCH cycle is accepted (minimum 1-cycle fetch).
  - imem_ready outside FETCH is ignored.
- EXEC:
  - imem_req = 0. instruction and instr_valid are held.
  - With stall = 1: remain in EXEC; pc, instruction and instr_valid are unchanged.
  - With stall = 0: at the clock edge, pc is loaded with next_pc, instr_valid goes to 0, instruction goes to NOP_INSTR, and state goes to FETCH.
- next_pc selection, all arithmetic modulo 2^32:
  - 4'b0001 jump: {pc_plus4[31:28], instruction[25:0], 2'b00}.
  - 4'b0010 jump register: {jr_target[31:2], 2'b00}. If jr_target[1:0] != 0, misalign_err is set and stays set until reset.
  - 4'b0011 branch taken: pc_plus4 + ({{14{instruction[15]}}, instruction[15:0], 2'b00}).
  - any other value: pc_plus4.
- pc_control is sampled only on the EXEC-exit edge; values at other times are ignored.
- Throughput: at most one instruction per 2 cycles (FETCH + EXEC), with zero memory wait and no stall.
- Wrap: pc = 32'hFFFF_FFFC sequentially advances to 32'h0000_0000, with no flag.
- Reset mid-FETCH: imem_req deasserts immediately (asynchronously). The pending fetch is discarded and the flow restarts from BOOT.
- Reset mid-EXEC: instr_valid drops immediately (asynchronously).
- pc[1:0] is always 2'b00.

Test Plan:
- Reset then sequential run, imem_ready tied 1, rdata = 32'h0000_0020 (add): pc runs 0, 4, 8; instr_valid pulses every other cycle; imem_req high only in FETCH.
- Memory wait, imem_ready low for 3 cycles at pc = 0x10: imem_req and imem_addr = 0x10 held for 4 cycles; instruction loads only on the ready edge.
- Jump at pc = 0x1000_0040, instruction 32'h0800_0100, pc_control = 1: next pc = 0x1000_0400.
- Branch, instruction imm = 16'hFFFE, pc = 0x100, pc_control = 3: next pc = 0x0FC. Same instruction with pc_control = 0: next pc = 0x104.
- Jump register with jr_target = 0x0000_2003, pc_control = 2: next pc = 0x2000; misalign_err = 1 and stays 1 through later instructions until rst.
- stall held 5 cycles in EXEC: pc and instruction stable, no imem_req. Assert rst during a later FETCH: imem_req = 0 before the next edge; after release, pc = RESET_VECTOR.
